// File: rtl/zmod_adc_spi_pkg.sv
// Shared constants, reset values, frame field widths and FSM states for the
// AD9648-style SPI configuration target.
package zmod_adc_spi_pkg;

    localparam int LP_RW_W    = 1;
    localparam int LP_W_W     = 2;
    localparam int LP_A_W     = 13;
    localparam int LP_D_W     = 8;
    localparam int LP_INSTR_W = LP_RW_W + LP_W_W + LP_A_W;

    localparam logic [LP_A_W-1:0] ADDR_CHIP_ID  = 13'h0001;
    localparam logic [LP_A_W-1:0] ADDR_CHSELECT = 13'h0005;
    localparam logic [LP_A_W-1:0] ADDR_PWRMODE  = 13'h0008;
    localparam logic [LP_A_W-1:0] ADDR_TESTMODE = 13'h000D;
    localparam logic [LP_A_W-1:0] ADDR_OMODE    = 13'h0014;

    localparam logic [LP_D_W-1:0] LP_CHSEL_RST = 8'h03;
    localparam logic [LP_D_W-1:0] LP_REG_RST   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } state_e;

    // Local-register readback: channel A wins whenever it is selected.
    function automatic logic [LP_D_W-1:0] pick_copy(
        input logic [LP_D_W-1:0] a_copy,
        input logic [LP_D_W-1:0] b_copy,
        input logic [1:0]        chsel
    );
        return chsel[0] ? a_copy : b_copy;
    endfunction

endpackage

// File: rtl/zmod_adc_spi_target_edge_sync.sv
// Pad synchronizer for sck/cs/sdio plus rise/fall detection on sck and cs;
// sdio leaves the chain at the same stage that feeds the edge detectors.
module spi_edge_sync #(
    parameter int P_SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_cs,
    input  logic i_sdio,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_rise,
    output logic o_cs_fall,
    output logic o_cs_low,
    output logic o_sdio
);
    localparam int         LP_STAGES = (P_SYNC_STAGES < 2) ? 2 : P_SYNC_STAGES;
    localparam logic [2:0] LP_IDLE   = 3'b011;   // {sdio, cs, sck} bus-idle levels

    logic [2:0] pad;
    logic [2:0] sync;
    logic [1:0] prev_q;

    assign pad = {i_sdio, i_cs, i_sck};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chain
            logic [LP_STAGES-1:0] chain_q;
            logic [LP_STAGES-1:0] chain_d;

            assign chain_d  = {chain_q[LP_STAGES-2:0], pad[gi]};
            assign sync[gi] = chain_q[LP_STAGES-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    chain_q <= {LP_STAGES{LP_IDLE[gi]}};
                end else begin
                    chain_q <= chain_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= LP_IDLE[1:0];
        end else begin
            prev_q <= sync[1:0];
        end
    end

    assign o_sck_rise = sync[0] & ~prev_q[0];
    assign o_sck_fall = ~sync[0] & prev_q[0];
    assign o_cs_rise  = sync[1] & ~prev_q[1];
    assign o_cs_fall  = ~sync[1] & prev_q[1];
    assign o_cs_low   = ~sync[1];
    assign o_sdio     = sync[2];

endmodule

// File: rtl/zmod_adc_spi_target.sv
// 3-wire SPI configuration target emulating the AD9648 register port.
// Readback over SDIO is built only when ZMOD_ADC_SPI_TARGET_READBACK_EN is defined.
module zmod_adc_spi_target
    import zmod_adc_spi_pkg::*;
#(
    parameter logic [7:0] P_CHIP_ID     = 8'h88,
    parameter int         P_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sck,
    input  logic       i_cs,
    input  logic       i_sdio,
    output logic       o_sdio,
    output logic       o_sdio_oe,
    output logic [7:0] o8_chselect,
    output logic [7:0] o8_pwrmode_a,
    output logic [7:0] o8_pwrmode_b,
    output logic [7:0] o8_testmode_a,
    output logic [7:0] o8_testmode_b,
    output logic [7:0] o8_omode_a,
    output logic [7:0] o8_omode_b,
    output logic       o_frame_done,
    output logic       o_frame_err
);
    logic sck_rise, sck_fall, cs_rise, cs_fall, cs_low, sdio_s;
    logic sck_rise_act;

    spi_edge_sync #(
        .P_SYNC_STAGES(P_SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .i_sck     (i_sck),
        .i_cs      (i_cs),
        .i_sdio    (i_sdio),
        .o_sck_rise(sck_rise),
        .o_sck_fall(sck_fall),
        .o_cs_rise (cs_rise),
        .o_cs_fall (cs_fall),
        .o_cs_low  (cs_low),
        .o_sdio    (sdio_s)
    );

    assign sck_rise_act = sck_rise & cs_low;

    state_e                state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [LP_INSTR_W-1:0] shift_q, shift_d;
    logic [LP_A_W-1:0]     addr_q, addr_d;
    logic [1:0]            bytes_left_q, bytes_left_d;
    logic                  stream_q, stream_d;
    logic                  frame_ok_q, frame_ok_d;
    logic                  done_q, done_d, err_q, err_d;
    logic [7:0]            chselect_q, chselect_d;
    logic [7:0]            pwrmode_a_q, pwrmode_a_d, pwrmode_b_q, pwrmode_b_d;
    logic [7:0]            testmode_a_q, testmode_a_d, testmode_b_q, testmode_b_d;
    logic [7:0]            omode_a_q, omode_a_d, omode_b_q, omode_b_d;

    logic [LP_INSTR_W-1:0] shift_in;
    logic [LP_A_W-1:0]     addr_dec;
    logic [LP_D_W-1:0]     wr_data;
    logic                  byte_end, wr_en;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        addr_d       = addr_q;
        bytes_left_d = bytes_left_q;
        stream_d     = stream_q;
        frame_ok_d   = frame_ok_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        byte_end     = 1'b0;
        wr_en        = 1'b0;
        shift_in     = {shift_q[LP_INSTR_W-2:0], sdio_s};
        wr_data      = shift_in[LP_D_W-1:0];
        addr_dec     = addr_q - 13'd1;

        if (cs_rise) begin
            state_d = ST_IDLE;
            if (state_q != ST_IDLE) begin
                if (frame_ok_q && (bit_cnt_q == 4'd0)) begin
                    done_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d    = ST_INSTR;
                        bit_cnt_d  = 4'd0;
                        frame_ok_d = 1'b0;
                    end
                end
                ST_INSTR: begin
                    if (sck_rise_act) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            bit_cnt_d    = 4'd0;
                            addr_d       = shift_in[LP_A_W-1:0];
                            bytes_left_d = shift_in[LP_A_W +: LP_W_W];
                            stream_d     = &shift_in[LP_A_W +: LP_W_W];
                            if (!shift_in[LP_INSTR_W-1]) begin
                                state_d = ST_WDATA;
                            end else begin
`ifdef ZMOD_ADC_SPI_TARGET_READBACK_EN
                                state_d = ST_RDATA;
`else
                                state_d    = ST_DONE;
                                frame_ok_d = 1'b1;
`endif
                            end
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise_act) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            wr_en    = 1'b1;
                            byte_end = 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_rise_act) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            byte_end = 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Byte bookkeeping shared by writes and reads: address walks downward.
            if (byte_end) begin
                bit_cnt_d  = 4'd0;
                frame_ok_d = 1'b1;
                addr_d     = addr_dec;
                if (!stream_q) begin
                    if (bytes_left_q == 2'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        bytes_left_d = bytes_left_q - 2'd1;
                    end
                end
            end
        end
    end

    // Local decode uses the chselect value in force before this byte commits.
    always_comb begin
        chselect_d   = chselect_q;
        pwrmode_a_d  = pwrmode_a_q;
        pwrmode_b_d  = pwrmode_b_q;
        testmode_a_d = testmode_a_q;
        testmode_b_d = testmode_b_q;
        omode_a_d    = omode_a_q;
        omode_b_d    = omode_b_q;
        if (wr_en) begin
            case (addr_q)
                ADDR_CHSELECT: chselect_d = {6'd0, wr_data[1:0]};
                ADDR_PWRMODE: begin
                    if (chselect_q[0]) pwrmode_a_d = wr_data;
                    if (chselect_q[1]) pwrmode_b_d = wr_data;
                end
                ADDR_TESTMODE: begin
                    if (chselect_q[0]) testmode_a_d = wr_data;
                    if (chselect_q[1]) testmode_b_d = wr_data;
                end
                ADDR_OMODE: begin
                    if (chselect_q[0]) omode_a_d = wr_data;
                    if (chselect_q[1]) omode_b_d = wr_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            addr_q       <= '0;
            bytes_left_q <= 2'd0;
            stream_q     <= 1'b0;
            frame_ok_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            chselect_q   <= LP_CHSEL_RST;
            pwrmode_a_q  <= LP_REG_RST;
            pwrmode_b_q  <= LP_REG_RST;
            testmode_a_q <= LP_REG_RST;
            testmode_b_q <= LP_REG_RST;
            omode_a_q    <= LP_REG_RST;
            omode_b_q    <= LP_REG_RST;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_q       <= addr_d;
            bytes_left_q <= bytes_left_d;
            stream_q     <= stream_d;
            frame_ok_q   <= frame_ok_d;
            done_q       <= done_d;
            err_q        <= err_d;
            chselect_q   <= chselect_d;
            pwrmode_a_q  <= pwrmode_a_d;
            pwrmode_b_q  <= pwrmode_b_d;
            testmode_a_q <= testmode_a_d;
            testmode_b_q <= testmode_b_d;
            omode_a_q    <= omode_a_d;
            omode_b_q    <= omode_b_d;
        end
    end

`ifdef ZMOD_ADC_SPI_TARGET_READBACK_EN
    logic [LP_A_W-1:0] rd_addr;
    logic [7:0]        rd_mux;
    logic [7:0]        rd_byte_q, rd_byte_d;
    logic              sdio_q, sdio_d, sdio_oe_q, sdio_oe_d;

    // Next read word: the instruction address at its last bit, else the next lower address.
    always_comb begin
        rd_mux  = LP_REG_RST;
        rd_addr = (state_q == ST_INSTR) ? shift_in[LP_A_W-1:0] : addr_dec;
        case (rd_addr)
            ADDR_CHIP_ID:  rd_mux = P_CHIP_ID;
            ADDR_CHSELECT: rd_mux = chselect_q;
            ADDR_PWRMODE:  rd_mux = pick_copy(pwrmode_a_q, pwrmode_b_q, chselect_q[1:0]);
            ADDR_TESTMODE: rd_mux = pick_copy(testmode_a_q, testmode_b_q, chselect_q[1:0]);
            ADDR_OMODE:    rd_mux = pick_copy(omode_a_q, omode_b_q, chselect_q[1:0]);
            default:       rd_mux = LP_REG_RST;
        endcase
    end

    always_comb begin
        rd_byte_d = rd_byte_q;
        sdio_d    = sdio_q;
        sdio_oe_d = sdio_oe_q;
        if (cs_rise) begin
            sdio_d    = 1'b0;
            sdio_oe_d = 1'b0;
        end else if ((state_q == ST_INSTR) && sck_rise_act && (bit_cnt_q == 4'd15)) begin
            rd_byte_d = rd_mux;
        end else if (state_q == ST_RDATA) begin
            if (sck_fall && cs_low) begin
                sdio_d    = rd_byte_q[7];
                rd_byte_d = {rd_byte_q[6:0], 1'b0};
                sdio_oe_d = 1'b1;
            end else if (byte_end) begin
                rd_byte_d = rd_mux;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_byte_q <= 8'h00;
            sdio_q    <= 1'b0;
            sdio_oe_q <= 1'b0;
        end else begin
            rd_byte_q <= rd_byte_d;
            sdio_q    <= sdio_d;
            sdio_oe_q <= sdio_oe_d;
        end
    end

    assign o_sdio    = sdio_q;
    assign o_sdio_oe = sdio_oe_q;
`else
    logic unused_sink;
    assign unused_sink = sck_fall ^ (^P_CHIP_ID);
    assign o_sdio      = 1'b0;
    assign o_sdio_oe   = 1'b0;
`endif

    assign o8_chselect   = chselect_q;
    assign o8_pwrmode_a  = pwrmode_a_q;
    assign o8_pwrmode_b  = pwrmode_b_q;
    assign o8_testmode_a = testmode_a_q;
    assign o8_testmode_b = testmode_b_q;
    assign o8_omode_a    = omode_a_q;
    assign o8_omode_b    = omode_b_q;
    assign o_frame_done  = done_q;
    assign o_frame_err   = err_q;

endmodule

// File: doc/zmod_adc_spi_target.md
Name: zmod_adc_spi_target

Overview:
- Synthesizable 3-wire SPI target that models the AD9648 configuration port. It is the responder to the ZMOD ADC configuration master.
- Decodes 24-bit-and-longer frames (RW | W[1:0] | A[12:0] | data bytes) and keeps a per-channel register file.
- Supports readback over the shared SDIO line.
- Used as an ADC emulator in loopback builds, and as a checker for the configuration sequencer.

Parameters:
- P_CHIP_ID, 8'h88, read-only value returned at address 0x01.
- P_SYNC_STAGES, 2, synchronizer depth on i_sck, i_cs, i_sdio (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x f_sck.
- rst  input  1  reset, asynchronous, active-low.
- i_sck  input  1  SPI clock; idles high; data sampled on rising edge.
- i_cs  input  1  chip select, active-low.
- i_sdio  input  1  SDIO as seen at the pad.
- o_sdio  output  1  read data to the pad.
- o_sdio_oe  output  1  pad output enable, active-high.
- o8_chselect  output  8  register 0x05.
- o8_pwrmode_a / o8_pwrmode_b  output  8  register 0x08, channel A / channel B copy.
- o8_testmode_a / o8_testmode_b  output  8  register 0x0D, channel A / channel B copy.
- o8_omode_a / o8_omode_b  output  8  register 0x14, channel A / channel B copy.
- o_frame_done  output  1  one-clk pulse when CS rises after at least one complete data byte.
- o_frame_err  output  1  one-clk pulse when CS rises mid-instruction or mid-byte.

Behaviour:
- Reset values:
  - chselect = 8'h03; all other registers = 8'h00.
  - o_sdio = 0, o_sdio_oe = 0, both pulses = 0.
  - FSM = IDLE.
- Synchronization and edge detection:
  - i_sck, i_cs, i_sdio pass through P_SYNC_STAGES flops, then one edge-detect flop.
  - An sck rise is acted on P_SYNC_STAGES+1 clk after the pad edge.
  - sdio is sampled from the same pipeline stage as the sck edge detect, so skew is equal.
- FSM states:
  - IDLE: wait for synchronized cs falling edge; on it, clear bit counter, go to INSTR.
  - INSTR: shift 16 bits MSB-first on sck rises; after bit 16 latch rw, w, addr; go to WDATA (rw=0) or RDATA (rw=1).
  - WDATA: shift 8 bits. On the 8th rise, commit the byte to addr in the same clk. Then decrement addr (13-bit wrap, 0x0000 -> 0x1FFF) and decrement the byte count.
  - RDATA: on each sck fall, drive the next bit of the read word MSB-first on o_sdio; o_sdio_oe=1 from the first fall until cs rises. Byte accounting matches WDATA.
  - DONE: reached when the byte count is exhausted; ignore further sck edges until cs rises.
- Byte count: W=00 -> 1 byte, 01 -> 2, 10 -> 3, 11 -> stream until cs rises.
- cs rising edge, from any state:
  - o_sdio_oe=0 in the same clk; return to IDLE.
  - Pulse o_frame_done if at least one byte completed and the bit counter is 0.
  - Otherwise pulse o_frame_err.
  - A partial byte is discarded and never committed.
- Register map:
  - 0x01: read-only, returns P_CHIP_ID; writes ignored.
  - 0x05: global; bits [7:2] write as 0, read as 0.
  - 0x08, 0x0D, 0x14 are local registers:
    - Write: updates the A copy if chselect[0], the B copy if chselect[1]; both if both set; neither if 00.
    - Read: returns the A copy if chselect[0] is set, else the B copy.
  - Unmapped addresses: writes dropped, reads return 8'h00.
- Write commit is visible on the outputs 1 clk after the 8th rise is detected.
- A chselect write affects the next byte's local decode, not the current one.
- sck edges while cs is high are ignored.
- Reset asserted mid-frame: everything returns to reset values immediately; the next cs fall starts a new frame.

Optional Feature:
- Macro: ZMOD_ADC_SPI_TARGET_READBACK_EN.
- Defined: RDATA behaves as above.
- Undefined:
  - rw=1 frames go to DONE after the instruction; o_sdio and o_sdio_oe are tied to 0.
  - o_frame_done still pulses on cs rise if the instruction completed.
  - No register changes result from the frame.

Decomposition:
- Package zmod_adc_spi_pkg holds:
  - address constants (0x01, 0x05, 0x08, 0x0D, 0x14);
  - reset values;
  - FSM state enum;
  - frame field widths (RW 1, W 2, A 13, D 8).
- One sub-module, spi_edge_sync: synchronizer plus rise/fall detect for sck and cs, with a delay-matched sdio output.

Test Plan:
- Frame 24'h000503 at f_sck = clk/8 -> o8_chselect = 8'h03, o_frame_done pulses once, o_frame_err stays 0.
- Frame 24'h000501, then 24'h001431 -> o8_omode_a = 8'h31, o8_omode_b stays 8'h00. Frame 24'h000502, then 24'h001421 -> o8_omode_b = 8'h21, o8_omode_a still 8'h31.
- Read frame 16'h8001 plus 8 clocks -> captured byte 8'h88, o_sdio_oe high for exactly the data phase. With the macro undefined -> o_sdio_oe never asserts.
- Frame 24'h000803 cut by a cs rise after 10 bits -> o_frame_err pulses, o8_pwrmode_a/b unchanged. The next full frame 24'h00083C -> both copies = 8'h3C.
- Streaming write 16'h600D then bytes 8'h40, 8'h11, 8'h22 with chselect = 03 -> testmode_a/b = 8'h40; bytes to 0x0C and 0x0B dropped; o_frame_done pulses.
- rst low mid-instruction -> all outputs return to reset values. A subsequent 24'h000500 frame applies normally: chselect = 8'h00.
